// File: rtl/reg_file_nr2w.sv
// Multi-port register file: NUM_RD registered read ports, two byte-enabled write
// ports, write-first bypass into the read path and an optional hardwired-zero register 0.
module reg_file_nr2w #(
   parameter  int WIDTH    = 32,
   parameter  int DEPTH    = 32,
   parameter  int NUM_RD   = 2,
   parameter  int ZERO_REG = 1,
   localparam int AW       = $clog2(DEPTH),
   localparam int BW       = WIDTH / 8
) (
   input  logic                    Clock,
   input  logic                    Reset,
   input  logic                    EN,
   input  logic                    W0_EN,
   input  logic [AW-1:0]           W0_ADDR,
   input  logic [BW-1:0]           W0_BE,
   input  logic [WIDTH-1:0]        W0_DATA,
   input  logic                    W1_EN,
   input  logic [AW-1:0]           W1_ADDR,
   input  logic [BW-1:0]           W1_BE,
   input  logic [WIDTH-1:0]        W1_DATA,
   input  logic [NUM_RD-1:0]       RD_EN,
   input  logic [NUM_RD*AW-1:0]    RD_ADDR,
   output logic [NUM_RD*WIDTH-1:0] Q,
   output logic [NUM_RD-1:0]       Q_VALID
);

   logic [DEPTH-1:0][WIDTH-1:0]  r_mem;
   logic [DEPTH-1:0][WIDTH-1:0]  w_mem_nxt;
   logic [NUM_RD-1:0][WIDTH-1:0] r_q;
   logic [NUM_RD-1:0][WIDTH-1:0] w_rd;
   logic [NUM_RD-1:0]            r_qv;

   // Post-write image of the array; port 1 is applied last so it wins per byte.
   // Addresses >= DEPTH match no row and so fall away naturally.
   always_comb begin
      w_mem_nxt = r_mem;
      for (int i = 0; i < DEPTH; i++) begin
         if (!(ZERO_REG != 0 && i == 0)) begin
            for (int b = 0; b < BW; b++) begin
               if (W1_EN && W1_ADDR == AW'(i) && W1_BE[b])
                  w_mem_nxt[i][8*b +: 8] = W1_DATA[8*b +: 8];
               else if (W0_EN && W0_ADDR == AW'(i) && W0_BE[b])
                  w_mem_nxt[i][8*b +: 8] = W0_DATA[8*b +: 8];
            end
         end
      end
   end

   // Reads select from the post-write image, which gives write-first bypass.
   genvar k;
   generate
      for (k = 0; k < NUM_RD; k++) begin : g_rd
         always_comb begin
            w_rd[k] = '0;
            for (int i = 0; i < DEPTH; i++) begin
               if (RD_ADDR[k*AW +: AW] == AW'(i) && !(ZERO_REG != 0 && i == 0))
                  w_rd[k] = w_mem_nxt[i];
            end
         end
      end
   endgenerate

   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_mem <= '0;
         r_q   <= '0;
         r_qv  <= '0;
      end else if (EN) begin
         r_mem <= w_mem_nxt;
         for (int p = 0; p < NUM_RD; p++) begin
            if (RD_EN[p]) r_q[p] <= w_rd[p];
         end
         r_qv <= RD_EN;
      end else begin
         r_qv <= '0;
      end
   end

   assign Q       = r_q;
   assign Q_VALID = r_qv;

endmodule

// File: tb/tb_reg_file_nr2w.sv
// Randomized bench for reg_file_nr2w: two instances (zero-reg/depth 32 and
// no-zero-reg/depth 20) share stimulus and are checked against an array model.
module tb_reg_file_nr2w;

   logic        Clock = 1'b0;
   logic        Reset, EN;
   logic        W0_EN, W1_EN;
   logic [4:0]  W0_ADDR, W1_ADDR;
   logic [3:0]  W0_BE, W1_BE;
   logic [31:0] W0_DATA, W1_DATA;
   logic [1:0]  RD_EN;
   logic [9:0]  RD_ADDR;
   logic [63:0] Q_a, Q_b;
   logic [1:0]  QV_a, QV_b;

   always #5 Clock = ~Clock;

   reg_file_nr2w #(.WIDTH(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(1)) dut_a (
      .Clock(Clock), .Reset(Reset), .EN(EN),
      .W0_EN(W0_EN), .W0_ADDR(W0_ADDR), .W0_BE(W0_BE), .W0_DATA(W0_DATA),
      .W1_EN(W1_EN), .W1_ADDR(W1_ADDR), .W1_BE(W1_BE), .W1_DATA(W1_DATA),
      .RD_EN(RD_EN), .RD_ADDR(RD_ADDR), .Q(Q_a), .Q_VALID(QV_a));

   reg_file_nr2w #(.WIDTH(32), .DEPTH(20), .NUM_RD(2), .ZERO_REG(0)) dut_b (
      .Clock(Clock), .Reset(Reset), .EN(EN),
      .W0_EN(W0_EN), .W0_ADDR(W0_ADDR), .W0_BE(W0_BE), .W0_DATA(W0_DATA),
      .W1_EN(W1_EN), .W1_ADDR(W1_ADDR), .W1_BE(W1_BE), .W1_DATA(W1_DATA),
      .RD_EN(RD_EN), .RD_ADDR(RD_ADDR), .Q(Q_b), .Q_VALID(QV_b));

   int n_chk  = 0;
   int n_pass = 0;

   logic [31:0] m   [2][32];
   logic [31:0] eq  [2][2];
   logic [1:0]  eqv [2];
   int          dep [2] = '{32, 20};
   bit          zr  [2] = '{1'b1, 1'b0};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [63:0] qof(input int d);
      return (d == 0) ? Q_a : Q_b;
   endfunction

   function automatic logic [1:0] qvof(input int d);
      return (d == 0) ? QV_a : QV_b;
   endfunction

   // Behavioural model: apply both writes (port 1 last), then read the result.
   task automatic model_update();
      for (int d = 0; d < 2; d++) begin
         if (Reset) begin
            for (int i = 0; i < 32; i++) m[d][i] = '0;
            eq[d][0] = '0; eq[d][1] = '0; eqv[d] = '0;
         end else if (!EN) begin
            eqv[d] = '0;
         end else begin
            for (int p = 0; p < 2; p++) begin
               logic        en;
               logic [4:0]  a;
               logic [3:0]  be;
               logic [31:0] dt;
               en = p ? W1_EN : W0_EN;   a  = p ? W1_ADDR : W0_ADDR;
               be = p ? W1_BE : W0_BE;   dt = p ? W1_DATA : W0_DATA;
               if (en && int'(a) < dep[d] && !(zr[d] && a == 0))
                  for (int b = 0; b < 4; b++)
                     if (be[b]) m[d][a][8*b +: 8] = dt[8*b +: 8];
            end
            for (int k = 0; k < 2; k++) begin
               logic [4:0] ra;
               ra = RD_ADDR[k*5 +: 5];
               if (RD_EN[k]) begin
                  eq[d][k] = (int'(ra) >= dep[d] || (zr[d] && ra == 0)) ? 32'h0 : m[d][ra];
                  eqv[d][k] = 1'b1;
               end else begin
                  eqv[d][k] = 1'b0;
               end
            end
         end
      end
   endtask

   task automatic check_all();
      logic [63:0] q;
      for (int d = 0; d < 2; d++) begin
         q = qof(d);
         for (int k = 0; k < 2; k++)
            chk($sformatf("q_d%0d_p%0d", d, k), q[k*32 +: 32], eq[d][k]);
         chk($sformatf("qv_d%0d", d), {30'b0, qvof(d)}, {30'b0, eqv[d]});
      end
   endtask

   task automatic tick();
      model_update();
      @(posedge Clock);
      #1;
      check_all();
   endtask

   task automatic idle();
      Reset = 1'b0; EN = 1'b1;
      W0_EN = 1'b0; W0_ADDR = '0; W0_BE = '0; W0_DATA = '0;
      W1_EN = 1'b0; W1_ADDR = '0; W1_BE = '0; W1_DATA = '0;
      RD_EN = '0; RD_ADDR = '0;
   endtask

   task automatic wr0(input logic [4:0] a, input logic [3:0] be, input logic [31:0] d);
      W0_EN = 1'b1; W0_ADDR = a; W0_BE = be; W0_DATA = d;
   endtask

   task automatic wr1(input logic [4:0] a, input logic [3:0] be, input logic [31:0] d);
      W1_EN = 1'b1; W1_ADDR = a; W1_BE = be; W1_DATA = d;
   endtask

   task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
      RD_EN = 2'b11; RD_ADDR = {a1, a0};
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 32; i++) m[d][i] = 'x;
         eq[d][0] = 'x; eq[d][1] = 'x; eqv[d] = 'x;
      end
      idle(); Reset = 1'b1; EN = 1'b0;
      @(negedge Clock); tick();
      idle(); wr0(5'd5, 4'hF, 32'hDEADBEEF); tick();
      // Reset with EN low and a read pending: Q_VALID must stay low
      idle(); Reset = 1'b1; EN = 1'b0; rd(5'd5, 5'd5); tick();
      chk("rst_qv", {30'b0, QV_a}, 32'h0);
      idle(); rd(5'd5, 5'd5); tick();
      chk("rst_reg5", Q_a[31:0], 32'h0);
      chk("rst_qv_after", {30'b0, QV_a}, 32'h3);

      idle(); wr0(5'd3, 4'hF, 32'h11223344); tick();
      idle(); wr0(5'd3, 4'b0101, 32'hAABBCCDD); tick();
      idle(); rd(5'd3, 5'd3); tick();
      chk("be_merge", Q_a[31:0], 32'h11BB33DD);

      idle(); wr0(5'd7, 4'hF, 32'h0); wr1(5'd7, 4'b0011, 32'hFFFFFFFF); tick();
      idle(); rd(5'd7, 5'd7); tick();
      chk("collision", Q_b[63:32], 32'h0000FFFF);

      idle(); wr0(5'd9, 4'hF, 32'h1); tick();
      idle(); wr0(5'd9, 4'hF, 32'h55); rd(5'd9, 5'd9); tick();
      chk("bypass_p0", Q_a[31:0], 32'h55);
      chk("bypass_p1", Q_a[63:32], 32'h55);

      idle(); wr0(5'd0, 4'hF, 32'h12345678); rd(5'd0, 5'd0); tick();
      chk("zero_byp_a", Q_a[31:0], 32'h0);
      chk("zero_byp_b", Q_b[31:0], 32'h12345678);
      idle(); rd(5'd0, 5'd0); tick();
      chk("zero_a", Q_a[31:0], 32'h0);
      chk("zero_b", Q_b[63:32], 32'h12345678);

      idle(); wr0(5'd4, 4'hF, 32'hCAFE); rd(5'd4, 5'd4); tick();
      idle(); EN = 1'b0; wr0(5'd2, 4'hF, 32'hBAD0BAD0); rd(5'd2, 5'd2); tick();
      chk("en_hold_q", Q_a[31:0], 32'hCAFE);
      chk("en_hold_qv", {30'b0, QV_a}, 32'h0);
      idle(); rd(5'd2, 5'd2); tick();
      chk("en_hold_reg2", Q_a[31:0], 32'h0);

      // Address 25 is in range for dut_a but out of range for dut_b
      idle(); wr0(5'd25, 4'hF, 32'h600DF00D); rd(5'd25, 5'd25); tick();
      chk("oor_b_q", Q_b[31:0], 32'h0);
      chk("oor_b_qv", {30'b0, QV_b}, 32'h3);
      chk("oor_a_q", Q_a[31:0], 32'h600DF00D);

      for (int c = 0; c < 400; c++) begin
         Reset   = ($urandom_range(0, 99) < 2);
         EN      = ($urandom_range(0, 9) != 0);
         W0_EN   = $urandom_range(0, 1);
         W0_ADDR = 5'($urandom_range(0, 23));
         W0_BE   = 4'($urandom);
         W0_DATA = $urandom;
         W1_EN   = $urandom_range(0, 1);
         W1_ADDR = ($urandom_range(0, 3) == 0) ? W0_ADDR : 5'($urandom_range(0, 23));
         W1_BE   = 4'($urandom);
         W1_DATA = $urandom;
         RD_EN   = 2'($urandom);
         RD_ADDR = {5'($urandom_range(0, 23)),
                    ($urandom_range(0, 2) == 0) ? W0_ADDR : 5'($urandom_range(0, 23))};
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/reg_file_nr2w.md
Name: reg_file_nr2w

Overview:
- Parametrised multi-port register file; next generation of the team's 2R1W register file.
- Configurable width, depth and read-port count, with two write ports and per-byte write enables.
- Registered reads with same-cycle write-first bypass, and an optional hardwired-zero register 0.
- Sits in the datapath between issue logic and the execution units.

Parameters:
- WIDTH, 32, data bits per register. Must be a multiple of 8.
- DEPTH, 32, number of registers. Must be at least 2. Need not be a power of 2.
- NUM_RD, 2, number of read ports, 1..8.
- ZERO_REG, 1, when 1 register 0 always reads 0 and writes to it are dropped.
- Local AW = $clog2(DEPTH); BW = WIDTH/8.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  reset, synchronous, active-high.
- EN  in  1  global enable; 0 freezes all state.
- W0_EN  in  1  write port 0 request.
- W0_ADDR  in  AW  write port 0 address.
- W0_BE  in  BW  write port 0 byte enables.
- W0_DATA  in  WIDTH  write port 0 data.
- W1_EN  in  1  write port 1 request.
- W1_ADDR  in  AW  write port 1 address.
- W1_BE  in  BW  write port 1 byte enables.
- W1_DATA  in  WIDTH  write port 1 data.
- RD_EN  in  NUM_RD  per-port read request.
- RD_ADDR  in  NUM_RD*AW  packed read addresses; port k is bits [k*AW +: AW].
- Q  out  NUM_RD*WIDTH  packed registered read data; port k is bits [k*WIDTH +: WIDTH].
- Q_VALID  out  NUM_RD  per-port data valid.

Behaviour:
- All state updates on the rising edge of Clock only; there is no asynchronous path.
- Reset:
  - Reset=1 at an edge clears every register, Q and Q_VALID to 0, regardless of EN.
  - Reset has priority over any write or read in the same cycle.
  - Reset mid-operation discards any pending write.
- EN=0 (Reset=0): registers and Q hold; Q_VALID is cleared to 0 on that edge.
- Writes (EN=1):
  - Byte b of register W0_ADDR takes W0_DATA byte b when W0_EN and W0_BE[b] are set. Port 1 likewise.
  - Bytes whose enable is clear are unchanged. An all-zero BE is a no-op.
- Write collision (W0_ADDR==W1_ADDR, both enabled): per byte, port 1 wins where W1_BE[b]=1; otherwise port 0's byte applies if W0_BE[b]=1.
- Out-of-range address (>= DEPTH): writes are ignored; reads return 0 with Q_VALID=1.
- ZERO_REG=1:
  - Writes to address 0 are ignored.
  - Reads of address 0 return 0, including under bypass.
- Reads:
  - Latency is 1 cycle. When RD_EN[k]=1 at edge t, Q[k] and Q_VALID[k]=1 are valid after edge t.
  - When RD_EN[k]=0, Q[k] holds its previous value and Q_VALID[k] goes 0.
- Bypass (write-first): a read in the same cycle as a write to the same address returns the post-write merged value, collision rules included.
- Read ports are independent. Any number of ports may read the same address in a cycle.
- Q and Q_VALID are driven only by flops; there is no combinational input-to-output path.
- Register storage is unaffected by reads.

Test Plan:
- Reset: write 0xDEADBEEF to reg 5, assert Reset with EN=0 -> next cycle a read of reg 5 gives Q=0, Q_VALID=1; during the Reset cycle Q_VALID=0.
- Byte enables: reg 3=0x11223344, then W0 writes 0xAABBCCDD with BE=4'b0101 -> reading reg 3 gives 0x11BB33DD.
- Collision: W0 writes 0x00000000 with BE=1111 and W1 writes 0xFFFFFFFF with BE=0011 to reg 7 in the same cycle -> reg 7 = 0x0000FFFF.
- Bypass: with reg 9=0x1, write 0x55 to reg 9 and read reg 9 on ports 0 and 1 in the same cycle -> next cycle both Q=0x55.
- Zero register: ZERO_REG=1, write 0x12345678 to reg 0 -> a read gives 0. With ZERO_REG=0 the same sequence reads 0x12345678.
- EN hold: Q[0]=0xCAFE, drive EN=0 with a W0 write to reg 2 and a read request -> Q[0] stays 0xCAFE, Q_VALID=0, reg 2 unchanged on a later read.
